// File: rtl/bit_deser_pkg.sv
// Shared types and sizes for the serial bit receiver (bit_deser_rx).
// The optional frame checksum is built only when BIT_DESER_CHECKSUM_EN is defined.
package bit_deser_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned BCNT_W         = 16;
  localparam int unsigned BIT_CNT_W      = 3;
  localparam int unsigned BIW_W          = 2;
  localparam int unsigned PART_W         = WORD_W - BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DRAIN,
    FLUSH,
    DONE
  } state_e;

  // Left-align 1..3 pending bytes (held right-aligned) into a zero-padded word.
  function automatic logic [WORD_W-1:0] pad_word(input logic [PART_W-1:0] part,
                                                 input logic [BIW_W-1:0]  nbytes);
    logic [WORD_W-1:0] w;
    w = '0;
    case (nbytes)
      BIW_W'(1): w = {part[BYTE_W-1:0],     24'h0};
      BIW_W'(2): w = {part[2*BYTE_W-1:0],   16'h0};
      BIW_W'(3): w = {part[3*BYTE_W-1:0],    8'h0};
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bit_deser_rx_if.sv
// Bit-stream input and RAM write / status output bundle of bit_deser_rx.
// checksum_o exists only when BIT_DESER_CHECKSUM_EN is defined.
interface bit_deser_rx_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 8
);

  logic              bit_in;
  logic              bit_valid_in;
  logic [LEN_W-1:0]  length_in;
  logic [ADDR_W-1:0] ram_base_in;
  logic [7:0]        byte_o;
  logic              byte_valid_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_data_o;
  logic              ram_wr_o;
  logic              frame_done_o;
  logic              frame_err_o;
  logic [ADDR_W-1:0] word_cnt_o;
`ifdef BIT_DESER_CHECKSUM_EN
  logic [7:0]        checksum_o;

  modport master (
    output bit_in, bit_valid_in, length_in, ram_base_in,
    input  byte_o, byte_valid_o, ram_addr_o, ram_data_o, ram_wr_o,
    input  frame_done_o, frame_err_o, word_cnt_o, checksum_o
  );

  modport slave (
    input  bit_in, bit_valid_in, length_in, ram_base_in,
    output byte_o, byte_valid_o, ram_addr_o, ram_data_o, ram_wr_o,
    output frame_done_o, frame_err_o, word_cnt_o, checksum_o
  );
`else
  modport master (
    output bit_in, bit_valid_in, length_in, ram_base_in,
    input  byte_o, byte_valid_o, ram_addr_o, ram_data_o, ram_wr_o,
    input  frame_done_o, frame_err_o, word_cnt_o
  );

  modport slave (
    input  bit_in, bit_valid_in, length_in, ram_base_in,
    output byte_o, byte_valid_o, ram_addr_o, ram_data_o, ram_wr_o,
    output frame_done_o, frame_err_o, word_cnt_o
  );
`endif

endinterface

// File: rtl/bit_deser_byte_shift.sv
// MSB-first byte assembler: 7 stored bits plus the live bit form the byte,
// a 3-bit counter marks the 8th bit and reports partially received bytes.
module bit_deser_byte_shift
  import bit_deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] byte_c,
  output logic              byte_stb_c,
  output logic              pending_c
);

  logic [BYTE_W-2:0]    sr_q;
  logic [BIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= byte_c[BYTE_W-2:0];
      cnt_q <= cnt_q + BIT_CNT_W'(1);
    end
  end

  assign byte_c     = {sr_q, bit_in};
  assign byte_stb_c = shift_en && (cnt_q == BIT_CNT_W'(BYTE_W - 1));
  assign pending_c  = (cnt_q != '0);

endmodule

// File: rtl/bit_deser_rx.sv
// Serial bit receiver: rebuilds bytes, packs big-endian 32-bit words into RAM
// and reports frame done / framing error. Option: BIT_DESER_CHECKSUM_EN.
module bit_deser_rx
  import bit_deser_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  bit_deser_rx_if.slave bus
);

  state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BIW_W-1:0]  biw_q, biw_d;
  logic [PART_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wr_q, ram_wr_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;

`ifdef BIT_DESER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [BYTE_W-1:0] chk_q, chk_d;
`endif

  logic              shift_en;
  logic              shift_clr;
  logic [BYTE_W-1:0] byte_c;
  logic              byte_stb_c;
  logic              pending_c;

  bit_deser_byte_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr        (shift_clr),
    .shift_en   (shift_en),
    .bit_in     (bus.bit_in),
    .byte_c     (byte_c),
    .byte_stb_c (byte_stb_c),
    .pending_c  (pending_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      bcnt_q       <= '0;
      biw_q        <= '0;
      word_q       <= '0;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wr_q     <= 1'b0;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
      word_cnt_q   <= '0;
`ifdef BIT_DESER_CHECKSUM_EN
      csum_q       <= '0;
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      bcnt_q       <= bcnt_d;
      biw_q        <= biw_d;
      word_q       <= word_d;
      wcnt_q       <= wcnt_d;
      err_q        <= err_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wr_q     <= ram_wr_d;
      done_q       <= done_d;
      ferr_q       <= ferr_d;
      word_cnt_q   <= word_cnt_d;
`ifdef BIT_DESER_CHECKSUM_EN
      csum_q       <= csum_d;
      chk_q        <= chk_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    addr_d       = addr_q;
    bcnt_d       = bcnt_q;
    biw_d        = biw_q;
    word_d       = word_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wr_d     = 1'b0;
    done_d       = 1'b0;
    ferr_d       = 1'b0;
    word_cnt_d   = word_cnt_q;
    shift_en     = 1'b0;
    shift_clr    = 1'b0;
`ifdef BIT_DESER_CHECKSUM_EN
    csum_d       = csum_q;
    chk_d        = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.bit_valid_in) begin
          shift_en = 1'b1;
          len_d    = bus.length_in;
          addr_d   = bus.ram_base_in;
          bcnt_d   = '0;
          biw_d    = '0;
          word_d   = '0;
          wcnt_d   = '0;
          err_d    = 1'b0;
`ifdef BIT_DESER_CHECKSUM_EN
          csum_d   = '0;
          chk_d    = '0;
`endif
          state_d  = RECV;
        end
      end

      RECV: begin
        if (bus.bit_valid_in) begin
          shift_en = 1'b1;
          if (byte_stb_c) begin
            byte_d       = byte_c;
            byte_valid_d = 1'b1;
`ifdef BIT_DESER_CHECKSUM_EN
            csum_d       = csum_q ^ byte_c;
`endif
            if (bcnt_q != '1) begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
            // Fourth byte completes the word: write in the same cycle as the byte pulse
            if (biw_q == BIW_W'(BYTES_PER_WORD - 1)) begin
              ram_wr_d   = 1'b1;
              ram_addr_d = addr_q;
              ram_data_d = {word_q, byte_c};
              addr_d     = addr_q + ADDR_W'(1);
              wcnt_d     = wcnt_q + ADDR_W'(1);
              biw_d      = '0;
              word_d     = '0;
            end else begin
              biw_d  = biw_q + BIW_W'(1);
              word_d = {word_q[PART_W-BYTE_W-1:0], byte_c};
            end
            if ((len_q != '0) && (bcnt_d == BCNT_W'(len_q))) begin
              state_d = DRAIN;
            end
          end
        end else begin
          state_d = FLUSH;
          err_d   = pending_c || ((len_q != '0) && (bcnt_q < BCNT_W'(len_q)));
        end
      end

      DRAIN: begin
        if (!bus.bit_valid_in) begin
          state_d = FLUSH;
          err_d   = 1'b0;
        end
      end

      FLUSH: begin
        shift_clr = 1'b1;
        ferr_d    = err_q;
        if (biw_q != '0) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_data_d = pad_word(word_q, biw_q);
          addr_d     = addr_q + ADDR_W'(1);
          wcnt_d     = wcnt_q + ADDR_W'(1);
          biw_d      = '0;
          word_d     = '0;
        end
        state_d = DONE;
      end

      DONE: begin
        done_d     = 1'b1;
        word_cnt_d = wcnt_q;
`ifdef BIT_DESER_CHECKSUM_EN
        chk_d      = csum_q;
`endif
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_data_o   = ram_data_q;
  assign bus.ram_wr_o     = ram_wr_q;
  assign bus.frame_done_o = done_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.word_cnt_o   = word_cnt_q;
`ifdef BIT_DESER_CHECKSUM_EN
  assign bus.checksum_o   = chk_q;
`endif

endmodule

// File: tb/tb_bit_deser_rx.sv
// Directed bench for bit_deser_rx: frame-level reference model plus literal pins.
// Checks checksum_o as well when BIT_DESER_CHECKSUM_EN is defined.
module tb_bit_deser_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bit_deser_rx_if #(.ADDR_W(9), .LEN_W(8)) bus ();

  bit_deser_rx #(.ADDR_W(9), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // Expected event streams from the frame model
  logic [7:0]  exp_byte_q[$];
  logic [8:0]  exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  bit          exp_wb_q[$];
  logic [8:0]  exp_fc_q[$];
  bit          exp_fe_q[$];
  logic [7:0]  exp_fx_q[$];

  logic [8:0]  log_a[$];
  logic [31:0] log_d[$];
  logic [8:0]  last_wcnt;
  bit          last_err;
  bit          err_seen = 1'b0;

  logic        bits_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
  endtask

  // Frame semantics from bit list, length and base; abort = reset mid-frame
  task automatic model_frame(input int len, input int base, input bit abort);
    int full, rem, nbytes, nwords;
    bit err;
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [31:0] w;
    full = bits_q.size() / 8;
    rem  = bits_q.size() % 8;
    if (len != 0 && full >= len) begin
      nbytes = len;
      err    = 1'b0;
    end else begin
      nbytes = full;
      err    = (rem != 0) || (len != 0 && full < len);
    end
    x = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], bits_q[i*8+k]};
      bytes.push_back(b);
      exp_byte_q.push_back(b);
      x = x ^ b;
    end
    if (abort) return;
    nwords = (nbytes + 3) / 4;
    for (int wi = 0; wi < nwords; wi++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (wi*4 + j < nbytes) w[31-8*j -: 8] = bytes[wi*4+j];
      exp_wa_q.push_back(9'((base + wi) % 512));
      exp_wd_q.push_back(w);
      exp_wb_q.push_back(wi*4 + 4 <= nbytes);
    end
    exp_fc_q.push_back(9'(nwords));
    exp_fe_q.push_back(err);
    exp_fx_q.push_back(x);
  endtask

  task automatic drive_frame(input int len, input int base);
    bus.length_in   = 8'(len);
    bus.ram_base_in = 9'(base);
    foreach (bits_q[i]) begin
      bus.bit_valid_in = 1'b1;
      bus.bit_in       = bits_q[i];
      @(posedge clk); #1;
    end
    bus.bit_valid_in = 1'b0;
    bus.bit_in       = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (exp_fc_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("done_timeout", 64'(exp_fc_q.size()), 64'd0);
  endtask

  task automatic start_frame();
    bits_q.delete();
    log_a.delete();
    log_d.delete();
  endtask

  // Compare DUT events against the model on every cycle
  always @(negedge clk) begin
    if (bus.byte_valid_o) begin
      if (exp_byte_q.size() == 0) check("unexpected_byte", 64'(bus.byte_o), 64'hx);
      else check("byte", 64'(bus.byte_o), 64'(exp_byte_q.pop_front()));
    end
    if (bus.ram_wr_o) begin
      log_a.push_back(bus.ram_addr_o);
      log_d.push_back(bus.ram_data_o);
      if (exp_wa_q.size() == 0) check("unexpected_write", 64'(bus.ram_data_o), 64'hx);
      else begin
        check("wr_addr", 64'(bus.ram_addr_o), 64'(exp_wa_q.pop_front()));
        check("wr_data", 64'(bus.ram_data_o), 64'(exp_wd_q.pop_front()));
        check("wr_with_byte", 64'(bus.byte_valid_o), 64'(exp_wb_q.pop_front()));
      end
    end
    if (bus.frame_err_o) err_seen = 1'b1;
    if (bus.frame_done_o) begin
      last_wcnt = bus.word_cnt_o;
      last_err  = err_seen;
      if (exp_fc_q.size() == 0) check("unexpected_done", 64'(bus.word_cnt_o), 64'hx);
      else begin
        check("word_cnt", 64'(bus.word_cnt_o), 64'(exp_fc_q.pop_front()));
        check("frame_err", 64'(err_seen), 64'(exp_fe_q.pop_front()));
`ifdef BIT_DESER_CHECKSUM_EN
        check("checksum", 64'(bus.checksum_o), 64'(exp_fx_q.pop_front()));
`else
        void'(exp_fx_q.pop_front());
`endif
      end
      err_seen = 1'b0;
    end
  end

  function automatic logic [63:0] out_vec();
    return 64'({bus.byte_o, bus.byte_valid_o, bus.ram_addr_o, bus.ram_data_o,
                bus.ram_wr_o, bus.frame_done_o, bus.frame_err_o, bus.word_cnt_o});
  endfunction

  initial begin
    bus.bit_in       = 1'b0;
    bus.bit_valid_in = 1'b0;
    bus.length_in    = '0;
    bus.ram_base_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", out_vec(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle with no stimulus
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", out_vec(), 64'd0);
    end
    @(posedge clk); #1;

    // Bounded frame, 8 bytes
    start_frame();
    for (int i = 1; i <= 8; i++) add_byte(8'(i * 8'h11));
    model_frame(8, 9'h010, 1'b0);
    drive_frame(8, 9'h010);
    wait_done();
    check("A_nwr", 64'(log_a.size()), 64'd2);
    if (log_a.size() == 2) begin
      check("A_a0", 64'(log_a[0]), 64'h010);
      check("A_d0", 64'(log_d[0]), 64'h11223344);
      check("A_a1", 64'(log_a[1]), 64'h011);
      check("A_d1", 64'(log_d[1]), 64'h55667788);
    end
    check("A_wcnt", 64'(last_wcnt), 64'd2);
    check("A_err", 64'(last_err), 64'd0);

    // Unbounded frame, 5 bytes
    start_frame();
    for (int i = 1; i <= 5; i++) add_byte(8'(8'hA0 + i));
    model_frame(0, 9'h020, 1'b0);
    drive_frame(0, 9'h020);
    wait_done();
    check("B_nwr", 64'(log_a.size()), 64'd2);
    if (log_a.size() == 2) begin
      check("B_d0", 64'(log_d[0]), 64'hA1A2A3A4);
      check("B_d1", 64'(log_d[1]), 64'hA5000000);
      check("B_a1", 64'(log_a[1]), 64'h021);
    end
    check("B_wcnt", 64'(last_wcnt), 64'd2);

    // Unbounded frame with 3 trailing bits
    start_frame();
    add_byte(8'hB1);
    add_byte(8'hB2);
    bits_q.push_back(1'b1); bits_q.push_back(1'b0); bits_q.push_back(1'b1);
    model_frame(0, 9'h030, 1'b0);
    drive_frame(0, 9'h030);
    wait_done();
    check("C_nwr", 64'(log_a.size()), 64'd1);
    if (log_a.size() == 1) check("C_d0", 64'(log_d[0]), 64'hB1B20000);
    check("C_err", 64'(last_err), 64'd1);
    check("C_wcnt", 64'(last_wcnt), 64'd1);

    // Address wrap, plus a 9th byte past the length that must be ignored
    start_frame();
    for (int i = 1; i <= 8; i++) add_byte(8'(i));
    add_byte(8'hFF);
    model_frame(8, 9'h1FF, 1'b0);
    drive_frame(8, 9'h1FF);
    wait_done();
    check("D_nwr", 64'(log_a.size()), 64'd2);
    if (log_a.size() == 2) begin
      check("D_a0", 64'(log_a[0]), 64'h1FF);
      check("D_a1", 64'(log_a[1]), 64'h000);
      check("D_d1", 64'(log_d[1]), 64'h05060708);
    end
    check("D_err", 64'(last_err), 64'd0);

    // Bounded frame cut short by valid falling early
    start_frame();
    add_byte(8'h5A);
    model_frame(3, 9'h050, 1'b0);
    drive_frame(3, 9'h050);
    wait_done();
    check("F_err", 64'(last_err), 64'd1);
    if (log_d.size() == 1) check("F_d0", 64'(log_d[0]), 64'h5A000000);
    else check("F_nwr", 64'(log_d.size()), 64'd1);

    // Reset after two bytes: no write, no done
    start_frame();
    add_byte(8'hDE);
    add_byte(8'hAD);
    model_frame(4, 9'h040, 1'b1);
    drive_frame(4, 9'h040);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("E_abort_nwr", 64'(log_a.size()), 64'd0);
    check("E_abort_state", out_vec(), 64'd0);

    start_frame();
    add_byte(8'hDE); add_byte(8'hAD); add_byte(8'hBE); add_byte(8'hEF);
    model_frame(4, 9'h040, 1'b0);
    drive_frame(4, 9'h040);
    wait_done();
    check("E_nwr", 64'(log_a.size()), 64'd1);
    if (log_a.size() == 1) begin
      check("E_a0", 64'(log_a[0]), 64'h040);
      check("E_d0", 64'(log_d[0]), 64'hDEADBEEF);
    end
`ifdef BIT_DESER_CHECKSUM_EN
    check("E_csum", 64'(bus.checksum_o), 64'h22);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("leftover_bytes", 64'(exp_byte_q.size()), 64'd0);
    check("leftover_writes", 64'(exp_wa_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
